// File: rtl/count_bcd_display.sv
// count_bcd_display: binary-to-BCD converter (sequential double-dabble,
// one iteration per clock) feeding a four-digit multiplexed 7-segment
// display driver with optional leading-zero blanking.
module count_bcd_display #(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  cnt_in,
    input  logic        cnt_valid,
    output logic        cnt_ready,
    output logic [15:0] bcd_out,
    output logic        conv_done,
    output logic [6:0]  seg,
    output logic [3:0]  dig_en
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);

    state_t      state_r, state_next_s;
    logic [9:0]  shift_r, shift_next_s;
    logic [15:0] scratch_r, scratch_next_s;
    logic [3:0]  iter_r, iter_next_s;
    logic [15:0] bcd_r, bcd_next_s;
    logic [15:0] adj_s;
    logic        done_next_s;
    logic        conv_done_r;
    logic        cnt_ready_r;
    logic [15:0] refresh_r, refresh_next_s;
    logic [1:0]  dig_sel_r, dig_sel_next_s;
    logic [6:0]  seg_r;
    logic [3:0]  dig_en_r;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = s[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Segment pattern {g,f,e,d,c,b,a} for one BCD digit; non-decimal codes go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    // Pattern for the selected digit, blanked when it is a leading zero.
    function automatic logic [6:0] digit_seg(input logic [15:0] bcd, input logic [1:0] sel);
        logic [3:0] d;
        logic       lead_zero;
        case (sel)
            2'd0: begin
                d         = bcd[3:0];
                lead_zero = 1'b0;
            end
            2'd1: begin
                d         = bcd[7:4];
                lead_zero = (bcd[15:4] == 12'd0);
            end
            2'd2: begin
                d         = bcd[11:8];
                lead_zero = (bcd[15:8] == 8'd0);
            end
            2'd3: begin
                d         = bcd[15:12];
                lead_zero = (bcd[15:12] == 4'd0);
            end
            default: begin
                d         = 4'd0;
                lead_zero = 1'b0;
            end
        endcase
        if ((BLANK_LZ == 1'b1) && lead_zero) begin
            return 7'h00;
        end else begin
            return seg_decode(d);
        end
    endfunction

    // One-hot digit enable from the 2-bit digit select.
    function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
        logic [3:0] r;
        case (sel)
            2'd0:    r = 4'b0001;
            2'd1:    r = 4'b0010;
            2'd2:    r = 4'b0100;
            2'd3:    r = 4'b1000;
            default: r = 4'b0001;
        endcase
        return r;
    endfunction

    assign adj_s = dabble_adjust(scratch_r);

    // Conversion FSM next-state and datapath: accept in IDLE, one dabble step per SHIFT cycle.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        scratch_next_s = scratch_r;
        iter_next_s    = iter_r;
        bcd_next_s     = bcd_r;
        done_next_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (cnt_valid) begin
                    shift_next_s   = cnt_in;
                    scratch_next_s = 16'd0;
                    iter_next_s    = 4'd0;
                    state_next_s   = SHIFT;
                end else begin
                    state_next_s   = IDLE;
                end
            end
            SHIFT: begin
                scratch_next_s = {adj_s[14:0], shift_r[9]};
                shift_next_s   = {shift_r[8:0], 1'b0};
                iter_next_s    = iter_r + 4'd1;
                if (iter_r == 4'd9) begin
                    // Tenth step: publish the finished result straight from the shift.
                    bcd_next_s   = {adj_s[14:0], shift_r[9]};
                    done_next_s  = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Refresh timer next-state: advance the digit select on every wrap.
    always_comb begin
        if (refresh_r == REFRESH_LAST) begin
            refresh_next_s = 16'd0;
            dig_sel_next_s = dig_sel_r + 2'd1;
        end else begin
            refresh_next_s = refresh_r + 16'd1;
            dig_sel_next_s = dig_sel_r;
        end
    end

    // Conversion state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shift_r   <= 10'd0;
            scratch_r <= 16'd0;
            iter_r    <= 4'd0;
            bcd_r     <= 16'd0;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            scratch_r <= scratch_next_s;
            iter_r    <= iter_next_s;
            bcd_r     <= bcd_next_s;
        end
    end

    // Refresh counter and digit select, free-running regardless of conversions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_r <= 16'd0;
            dig_sel_r <= 2'd0;
        end else begin
            refresh_r <= refresh_next_s;
            dig_sel_r <= dig_sel_next_s;
        end
    end

    // Output registers, loaded from next-state so they track bcd_out and select without lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ready_r <= 1'b1;
            conv_done_r <= 1'b0;
            seg_r       <= 7'h3F;
            dig_en_r    <= 4'b0001;
        end else begin
            cnt_ready_r <= (state_next_s == IDLE);
            conv_done_r <= done_next_s;
            seg_r       <= digit_seg(bcd_next_s, dig_sel_next_s);
            dig_en_r    <= sel_onehot(dig_sel_next_s);
        end
    end

    assign cnt_ready = cnt_ready_r;
    assign conv_done = conv_done_r;
    assign bcd_out   = bcd_r;
    assign seg       = seg_r;
    assign dig_en    = dig_en_r;

endmodule

// File: tb/tb_count_bcd_display.sv
// Self-checking bench for count_bcd_display: two instances (blanking on with
// a 4-cycle refresh, blanking off with a 3-cycle refresh) share one stimulus
// stream; expectations come from decimal arithmetic on the converted value.
module tb_count_bcd_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  cnt_in;
    logic        cnt_valid;

    logic        ready_a, done_a, ready_b, done_b;
    logic [15:0] bcd_a, bcd_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  en_a, en_b;

    int errors = 0;
    int checks = 0;
    int edges  = 0;
    int exp_val = 0;

    int         pow10  [4]  = '{1, 10, 100, 1000};
    logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    count_bcd_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
        .cnt_ready(ready_a), .bcd_out(bcd_a), .conv_done(done_a),
        .seg(seg_a), .dig_en(en_a)
    );

    count_bcd_display #(.REFRESH_DIV(3), .BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
        .cnt_ready(ready_b), .bcd_out(bcd_b), .conv_done(done_b),
        .seg(seg_b), .dig_en(en_b)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset released; the display position follows from it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int val, input int pos, input bit blank);
        int d;
        d = (val / pow10[pos]) % 10;
        if (blank && pos != 0 && val < pow10[pos]) return 7'h00;
        return segtab[d];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_disp();
        int sa, sb;
        sa = (edges / 4) % 4;
        sb = (edges / 3) % 4;
        chk("dig_en_a", 32'(en_a), 32'(1) << sa);
        chk("seg_a", 32'(seg_a), 32'(exp_seg(exp_val, sa, 1'b1)));
        chk("dig_en_b", 32'(en_b), 32'(1) << sb);
        chk("seg_b", 32'(seg_b), 32'(exp_seg(exp_val, sb, 1'b0)));
    endtask

    task automatic chk_state(input string tag, input logic rdy, input logic dn);
        chk({tag, "_ready_a"}, 32'(ready_a), 32'(rdy));
        chk({tag, "_ready_b"}, 32'(ready_b), 32'(rdy));
        chk({tag, "_done_a"}, 32'(done_a), 32'(dn));
        chk({tag, "_done_b"}, 32'(done_b), 32'(dn));
        chk({tag, "_bcd_a"}, 32'(bcd_a), 32'(to_bcd(exp_val)));
        chk({tag, "_bcd_b"}, 32'(bcd_b), 32'(to_bcd(exp_val)));
        chk_disp();
    endtask

    // Called at a falling edge with the block idle. With chain set, cnt_valid
    // stays high carrying nxt so that value transfers on the first idle edge.
    task automatic conv(input int v, input bit chain, input int nxt);
        chk("entry_ready_a", 32'(ready_a), 32'd1);
        cnt_in    = 10'(v);
        cnt_valid = 1'b1;
        @(negedge clk);
        chk_state("xfer", 1'b0, 1'b0);
        if (chain) begin
            cnt_in    = 10'(nxt);
            cnt_valid = 1'b1;
        end else begin
            cnt_valid = 1'b0;
        end
        for (int k = 1; k <= 10; k++) begin
            if (!chain) cnt_in = 10'($urandom);
            @(negedge clk);
            if (k < 10) begin
                chk_state("shift", 1'b0, 1'b0);
            end else begin
                exp_val = v;
                chk_state("result", 1'b1, 1'b1);
            end
        end
    endtask

    task automatic idle(input int n);
        cnt_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            cnt_in = 10'($urandom);
            @(negedge clk);
            chk_state("idle", 1'b1, 1'b0);
        end
    endtask

    // Start converting v, assert reset after `iters` dabble steps, release it
    // at a falling edge so the next transfer can use the very first edge.
    task automatic abort(input int v, input int iters);
        cnt_in    = 10'(v);
        cnt_valid = 1'b1;
        @(negedge clk);
        cnt_valid = 1'b0;
        repeat (iters) @(negedge clk);
        chk("pre_abort_ready_a", 32'(ready_a), 32'd0);
        rst_n = 1'b0;
        #1;
        exp_val = 0;
        chk_state("abort_now", 1'b1, 1'b0);
        @(negedge clk);
        chk_state("abort_held", 1'b1, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int v, w;
        rst_n     = 1'b0;
        cnt_valid = 1'b0;
        cnt_in    = 10'd0;
        repeat (2) @(negedge clk);
        chk_state("reset", 1'b1, 1'b0);
        rst_n = 1'b1;

        // Zero converts on the first edge after reset; all digits cycle through.
        conv(0, 1'b0, 0);
        idle(16);

        // Largest input.
        conv(1023, 1'b0, 0);
        idle(2);

        // Valid held across a conversion: 42 is taken on the first idle edge.
        conv(999, 1'b1, 42);
        conv(42, 1'b0, 0);
        idle(3);

        // Reset in the middle of converting 512.
        abort(512, 5);
        conv(1002, 1'b0, 0);
        idle(17);

        // Single-digit value: blanking versus full display.
        conv(5, 1'b0, 0);
        idle(17);

        // Random values, with random gaps and occasional back-to-back pairs.
        for (int r = 0; r < 12; r++) begin
            v = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) == 0) begin
                w = int'($urandom_range(0, 1023));
                conv(v, 1'b1, w);
                conv(w, 1'b0, 0);
            end else begin
                conv(v, 1'b0, 0);
            end
            idle(int'($urandom_range(1, 5)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
